ssp_txfifo_cntl_param: RTL and testbench

Parametrised control block for the SSP transmit FIFO. It keeps the write and read pointers, the wrap bit and the fill level, all in the PCLK domain. It generates TNF/TFE/BSY status, a programmable-watermark TX service interrupt, and a sticky overflow interrupt. It also provides a synchronous flush. It sits between the APB register block (SSPDR writes) and the FIFO register file, and takes a synchronised read toggle from the SSPCLK-domain transmit controller.

---
 rtl/ssp_txfifo_cntl_param.sv | 115 +++++++++++
 tb/tb_ssp_txfifo_cntl_param.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ssp_txfifo_cntl_param.sv
// SSP transmit FIFO control: pointers, wrap bit, fill level, status flags and TX interrupts.
// Everything runs in the PCLK domain; pops arrive as a pre-synchronised level toggle.
module ssp_txfifo_cntl_param #(
  parameter int unsigned AW = 3
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          TxWr,
  input  logic          RdIncTgl,
  input  logic          TestRdInc,
  input  logic          TxRxBsySync,
  input  logic          Flush,
  input  logic [AW:0]   TxWmLvl,
  input  logic          TXIM,
  input  logic          TXOIM,
  input  logic          TXOIC,
  output logic          RegFileWrEn,
  output logic [AW-1:0] WrPtr,
  output logic [AW-1:0] RdPtr,
  output logic [AW:0]   FillLvl,
  output logic          TNF,
  output logic          TFE,
  output logic          TxDataAvlbl,
  output logic          BSY,
  output logic          TXRIS,
  output logic          TXMIS,
  output logic          TXORIS,
  output logic          TXOMIS
);

  localparam logic [AW:0] FullLvl   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AlmostLvl = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] OneLvl    = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wrap_q, wrap_d;
  logic          tnf_q, tnf_d;
  logic          avl_q, avl_d;
  logic          txris_q, txris_d;
  logic          txoris_q, txoris_d;
  logic          del_tgl_q;

  logic [AW:0]   fill;
  logic          rd_edge, wr_ok, rd_ok, ovf;

  assign fill    = {wrap_q, wr_ptr_q} - {1'b0, rd_ptr_q};
  assign rd_edge = RdIncTgl ^ del_tgl_q;
  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
  assign wr_ok   = PRESETn & TxWr & ~Flush & (tnf_q | rd_edge);
  assign rd_ok   = avl_q & ~Flush & (rd_edge | TestRdInc);
  assign ovf     = TxWr & ~tnf_q & ~rd_edge & ~Flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wrap_d   = wrap_q;
    tnf_d    = tnf_q;
    avl_d    = avl_q;
    txris_d  = (fill <= TxWmLvl);
    txoris_d = ovf | (txoris_q & ~TXOIC);
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wrap_d   = 1'b0;
      tnf_d    = 1'b1;
      avl_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      // Simultaneous wraps of both pointers leave their relative phase unchanged.
      wrap_d = wrap_q ^ ((&wr_ptr_q & wr_ok) ^ (&rd_ptr_q & rd_ok));
      if (fill == AlmostLvl && wr_ok && !rd_ok) tnf_d = 1'b0;
      else if (fill == FullLvl && rd_ok && !wr_ok) tnf_d = 1'b1;
      if (fill == '0 && wr_ok) avl_d = 1'b1;
      else if (fill == OneLvl && rd_ok && !wr_ok) avl_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wrap_q    <= 1'b0;
      tnf_q     <= 1'b1;
      avl_q     <= 1'b0;
      txris_q   <= 1'b1;
      txoris_q  <= 1'b0;
      del_tgl_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wrap_q    <= wrap_d;
      tnf_q     <= tnf_d;
      avl_q     <= avl_d;
      txris_q   <= txris_d;
      txoris_q  <= txoris_d;
      del_tgl_q <= RdIncTgl;
    end
  end

  assign RegFileWrEn = wr_ok;
  assign WrPtr       = wr_ptr_q;
  assign RdPtr       = rd_ptr_q;
  assign FillLvl     = fill;
  assign TNF         = tnf_q;
  assign TxDataAvlbl = avl_q;
  assign TFE         = ~avl_q;
  assign BSY         = avl_q | TxRxBsySync;
  assign TXRIS       = txris_q;
  assign TXMIS       = txris_q & TXIM;
  assign TXORIS      = txoris_q;
  assign TXOMIS      = txoris_q & TXOIM;

endmodule

// File: tb/tb_ssp_txfifo_cntl_param.sv
// Bench for ssp_txfifo_cntl_param: directed vector table, corner sequences and randomized
// traffic checked against a count-based FIFO model.
module tb_ssp_txfifo_cntl_param;

  localparam int AW = 3;
  localparam int D  = 1 << AW;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          TxWr = 1'b0, RdIncTgl = 1'b0, TestRdInc = 1'b0, TxRxBsySync = 1'b0;
  logic          Flush = 1'b0, TXIM = 1'b0, TXOIM = 1'b0, TXOIC = 1'b0;
  logic [AW:0]   TxWmLvl = '0;
  logic          RegFileWrEn, TNF, TFE, TxDataAvlbl, BSY, TXRIS, TXMIS, TXORIS, TXOMIS;
  logic [AW-1:0] WrPtr, RdPtr;
  logic [AW:0]   FillLvl;

  ssp_txfifo_cntl_param #(.AW(AW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .TxWr(TxWr), .RdIncTgl(RdIncTgl), .TestRdInc(TestRdInc),
    .TxRxBsySync(TxRxBsySync), .Flush(Flush), .TxWmLvl(TxWmLvl), .TXIM(TXIM), .TXOIM(TXOIM),
    .TXOIC(TXOIC), .RegFileWrEn(RegFileWrEn), .WrPtr(WrPtr), .RdPtr(RdPtr), .FillLvl(FillLvl),
    .TNF(TNF), .TFE(TFE), .TxDataAvlbl(TxDataAvlbl), .BSY(BSY), .TXRIS(TXRIS), .TXMIS(TXMIS),
    .TXORIS(TXORIS), .TXOMIS(TXOMIS)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  // Model: entries counted as integers, pointers as running counts modulo depth.
  int m_fill, m_wr, m_rd;
  bit m_txris, m_txoris, m_prev;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill = 0; m_wr = 0; m_rd = 0; m_txris = 1; m_txoris = 0; m_prev = 0;
  endtask

  task automatic check_state();
    chk("WrPtr", int'(WrPtr), m_wr % D);
    chk("RdPtr", int'(RdPtr), m_rd % D);
    chk("FillLvl", int'(FillLvl), m_fill);
    chk("TNF", int'(TNF), int'(m_fill < D));
    chk("TFE", int'(TFE), int'(m_fill == 0));
    chk("TxDataAvlbl", int'(TxDataAvlbl), int'(m_fill > 0));
    chk("BSY", int'(BSY), int'((m_fill > 0) || TxRxBsySync));
    chk("TXRIS", int'(TXRIS), int'(m_txris));
    chk("TXMIS", int'(TXMIS), int'(m_txris && TXIM));
    chk("TXORIS", int'(TXORIS), int'(m_txoris));
    chk("TXOMIS", int'(TXOMIS), int'(m_txoris && TXOIM));
  endtask

  // One PCLK cycle: drive at negedge, check write enable before the edge, state after it.
  task automatic step(input bit wr, input bit tgl, input bit tst, input bit fl, input bit oic,
                      input int wm, input bit im, input bit oim, input bit bsy,
                      output bit wen_seen);
    bit rd_edge, full, wr_ok, rd_ok, ovf;
    @(negedge PCLK);
    TxWr = wr; RdIncTgl = tgl; TestRdInc = tst; Flush = fl; TXOIC = oic;
    TxWmLvl = (AW+1)'(wm); TXIM = im; TXOIM = oim; TxRxBsySync = bsy;
    #1;
    rd_edge = tgl ^ m_prev;
    full    = (m_fill == D);
    wr_ok   = wr && !fl && (!full || rd_edge);
    rd_ok   = (m_fill > 0) && !fl && (rd_edge || tst);
    ovf     = wr && full && !rd_edge && !fl;
    wen_seen = RegFileWrEn;
    chk("RegFileWrEn", int'(RegFileWrEn), int'(wr_ok));
    @(posedge PCLK);
    m_txris  = (m_fill <= wm);
    m_txoris = ovf || (m_txoris && !oic);
    if (fl) begin
      m_fill = 0; m_wr = 0; m_rd = 0;
    end else begin
      m_wr += int'(wr_ok);
      m_rd += int'(rd_ok);
      m_fill = m_fill + int'(wr_ok) - int'(rd_ok);
    end
    m_prev = tgl;
    #1;
    check_state();
  endtask

  typedef struct {
    bit wr, tgl, tst, fl, oic;
    int e_wen, e_fill, e_tnf, e_txris, e_txoris;
  } vec_t;

  vec_t tv[13];
  bit   wen;
  bit   tg;

  initial begin
    for (int k = 1; k <= 8; k++)
      tv[k-1] = '{1, 0, 0, 0, 0, 1, k, int'(k < 8), int'(k - 1 <= 4), 0};
    tv[8]  = '{1, 0, 0, 0, 0, 0, 8, 0, 0, 1};  // overflow, write dropped
    tv[9]  = '{0, 0, 0, 0, 1, 0, 8, 0, 0, 0};  // overflow clear
    tv[10] = '{1, 1, 0, 0, 0, 1, 8, 0, 0, 0};  // write with pop on full
    tv[11] = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0};  // flush beats write and test pop
    tv[12] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 0};  // TXRIS recovers a cycle later

    // Reset state, with a write strobe held during reset.
    model_reset();
    TxWr = 1'b1;
    #12;
    chk("RegFileWrEn_in_reset", int'(RegFileWrEn), 0);
    check_state();
    TxWr = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].wr, tv[i].tgl, tv[i].tst, tv[i].fl, tv[i].oic, 4, 1, 1, 0, wen);
      chk($sformatf("tv%0d_wen", i), int'(wen), tv[i].e_wen);
      chk($sformatf("tv%0d_fill", i), int'(FillLvl), tv[i].e_fill);
      chk($sformatf("tv%0d_tnf", i), int'(TNF), tv[i].e_tnf);
      chk($sformatf("tv%0d_txris", i), int'(TXRIS), tv[i].e_txris);
      chk($sformatf("tv%0d_txoris", i), int'(TXORIS), tv[i].e_txoris);
    end
    tg = 1'b1;

    // 20 write/pop pairs at level 3: pointers wrap several times, level must hold.
    for (int i = 0; i < 3; i++) step(1, tg, 0, 0, 0, 4, 0, 0, 0, wen);
    for (int i = 0; i < 20; i++) begin
      tg = ~tg;
      step(1, tg, 0, 0, 0, 4, 0, 0, 1, wen);
      chk("pair_fill", int'(FillLvl), 3);
    end

    // Flush at level 5 together with a write and a pop.
    step(0, tg, 0, 1, 0, 2, 1, 0, 0, wen);
    for (int i = 0; i < 5; i++) step(1, tg, 0, 0, 0, 2, 1, 0, 0, wen);
    tg = ~tg;
    step(1, tg, 0, 1, 0, 2, 1, 0, 0, wen);
    chk("flush_wen", int'(wen), 0);
    chk("flush_fill", int'(FillLvl), 0);
    chk("flush_tfe", int'(TFE), 1);
    chk("flush_tnf", int'(TNF), 1);
    step(0, tg, 0, 0, 0, 2, 1, 0, 0, wen);
    chk("flush_txris", int'(TXRIS), 1);

    // Asynchronous reset at level 3, with a toggle pending at release.
    for (int i = 0; i < 3; i++) step(1, tg, 0, 0, 0, 1, 0, 0, 0, wen);
    @(negedge PCLK); #2 PRESETn = 1'b0;
    #1;
    model_reset();
    chk("rst_wrptr", int'(WrPtr), 0);
    chk("rst_rdptr", int'(RdPtr), 0);
    chk("rst_tfe", int'(TFE), 1);
    chk("rst_tnf", int'(TNF), 1);
    chk("rst_txris", int'(TXRIS), 1);
    chk("rst_txoris", int'(TXORIS), 0);
    RdIncTgl = 1'b1;
    tg = 1'b1;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    step(0, tg, 0, 0, 0, 1, 0, 0, 0, wen);
    chk("rst_pop_ignored_rd", int'(RdPtr), 0);
    chk("rst_pop_ignored_fill", int'(FillLvl), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 40) tg = ~tg;
      step($urandom_range(0, 99) < 60, tg, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10,
           int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), wen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
